// File: rtl/mem_lsu.sv
// mem_lsu: byte/half/word load-store unit between the CPU datapath and a word memory port.
// Checks alignment, drives strobes and replicated store data, extends load data, times out.
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam int TM1 = TIMEOUT > 0 ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0] off, off_d, size, size_d;
    logic sign, sign_d;
    logic req_d, we_d, rv_d, err_d;
    logic [31:0] addr_d, wdata_d, rdata_d, sh, ext;
    logic [3:0] strb_d, strb;
    logic [31:0] rep;
    logic bad;

    assign req_ready = state == IDLE;
    assign bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && |req_addr[1:0]);
    assign strb = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                  req_size == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
    assign rep = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                 req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    // word accesses are aligned, so off=0 leaves the word unshifted
    assign sh = mem_rdata >> {off, 3'b000};
    assign ext = size == 2'b00 ? (sign ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]}) :
                 size == 2'b01 ? (sign ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]}) : sh;

    always_comb begin
        state_d = state;
        cnt_d = cnt;
        off_d = off;
        size_d = size;
        sign_d = sign;
        req_d = mem_req;
        we_d = mem_we;
        addr_d = mem_addr;
        strb_d = mem_wstrb;
        wdata_d = mem_wdata;
        rv_d = 1'b0;
        rdata_d = resp_rdata;
        err_d = resp_error;
        case (state)
            IDLE: if (req_valid) begin
                off_d = req_addr[1:0];
                size_d = req_size;
                sign_d = req_sign;
                if (bad) begin
                    state_d = RESP;
                    rv_d = 1'b1;
                    rdata_d = '0;
                    err_d = 1'b1;
                end else begin
                    state_d = ACCESS;
                    req_d = 1'b1;
                    we_d = req_we;
                    addr_d = {req_addr[31:2], 2'b00};
                    strb_d = req_we ? strb : 4'b0000;
                    wdata_d = req_we ? rep : '0;
                end
            end
            ACCESS: if (mem_ack) begin
                state_d = RESP;
                req_d = 1'b0;
                we_d = 1'b0;
                rv_d = 1'b1;
                rdata_d = mem_we ? '0 : ext;
                err_d = 1'b0;
            end else if (TIMEOUT > 0 && cnt == CW'(TM1)) begin
                state_d = RESP;
                req_d = 1'b0;
                we_d = 1'b0;
                rv_d = 1'b1;
                rdata_d = '0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt + 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            off <= '0;
            size <= '0;
            sign <= 1'b0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            off <= off_d;
            size <= size_d;
            sign <= sign_d;
            mem_req <= req_d;
            mem_we <= we_d;
            mem_addr <= addr_d;
            mem_wstrb <= strb_d;
            mem_wdata <= wdata_d;
            resp_valid <= rv_d;
            resp_rdata <= rdata_d;
            resp_error <= err_d;
        end
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit between the multicycle CPU datapath and a word-organised memory port.
- Takes one byte, half or word request at a time over a valid/ready handshake.
- Checks alignment, builds the word address, byte strobes and lane-replicated write data, and waits for the memory acknowledge with a timeout.
- Returns load data sign- or zero-extended, plus an error flag that drives the control unit's error input.

Parameters:
- TIMEOUT, 16: maximum cycles in ACCESS without mem_ack before error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_sign  in  1  0=sign-extend load, 1=zero-extend (funct3[2] polarity)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned, illegal size or timeout; valid with resp_valid
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address, bits [1:0]=00
- mem_wstrb  out  4  byte-lane write strobes; 0000 for loads
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completed the access this cycle
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_error all 0; timeout counter 0.
  - req_ready=1 while in IDLE, including during reset.
- All outputs except req_ready are registered.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Handshake is req_valid && req_ready. Latch we, addr, wdata, size and sign.
  - Error check: size 11 is illegal; half with addr[0]=1 and word with addr[1:0]!=00 are misaligned. Any of these -> RESP with error=1, rdata=0, and mem_req is never asserted.
  - Otherwise -> ACCESS, with mem_req=1 from the next cycle. mem_addr={addr[31:2],2'b00}; mem_we=we.
  - Store strobes: byte -> 0001<<addr[1:0]; half -> 0011<<addr[1:0]; word -> 1111.
  - Store data: byte replicated into all 4 lanes; half replicated into both halves; word as-is.
  - Loads: mem_wstrb=0000, mem_wdata=0.
- ACCESS:
  - mem_req and all mem_* outputs are held stable until mem_ack. The counter increments every ACCESS cycle without ack.
  - On mem_ack: mem_req=0 next cycle; state -> RESP.
  - Load extraction: shift mem_rdata right by addr[1:0]*8, keep the low 8 or 16 bits, then extend per sign. Word loads are passed through unchanged.
  - Store: rdata=0.
  - When the counter reaches TIMEOUT (TIMEOUT>0) without ack: mem_req=0, error=1, rdata=0, -> RESP. If mem_ack arrives in the same cycle the counter hits TIMEOUT, the ack wins: no error.
- RESP:
  - resp_valid=1 for exactly one cycle with rdata and error, then IDLE. The counter clears.
  - resp_rdata and resp_error hold their values until the next response.
  - req_ready=0 in ACCESS and RESP; requests arriving then are not accepted and must be held by the requester.
- mem_ack outside ACCESS is ignored.
- Latency for an aligned access with mem_ack in mem_req's first cycle:
  - accept at edge N, mem_req high in cycle N+1, resp_valid in cycle N+2.
  - Next accept is possible at edge N+3.
- Error latency: resp_valid in the cycle after accept.
- Reset mid-operation: mem_req drops immediately and no response is generated for the aborted request.

Test Plan:
- Load byte, addr=0x1003, sign=0, mem_rdata=0x80FF_0000 acked in first cycle -> mem_addr=0x1000, mem_wstrb=0000, resp_rdata=0xFFFF_FF80, resp_error=0, resp_valid exactly 2 cycles after accept.
- Store half, addr=0x2002, wdata=0x1234_ABCD -> mem_wstrb=1100, mem_wdata=0xABCD_ABCD, mem_we=1; after ack resp_valid=1 with resp_rdata=0.
- Load half with sign=1, addr=0x2002, mem_rdata=0x8001_7FFF -> resp_rdata=0x0000_8001.
- Load word addr=0x3002; then size=11 at addr=0x3000 -> each gives resp_error=1 one cycle after accept, mem_req never asserted.
- TIMEOUT=4, store word with mem_ack held low -> mem_req high exactly 4 cycles then low; resp_error=1; a later mem_ack pulse is ignored and req_ready=1 again.
- Assert rst=0 while in ACCESS -> mem_req=0 immediately and no resp_valid. After release, a new word load at addr=0x0 with mem_rdata=0xDEAD_BEEF -> resp_rdata=0xDEAD_BEEF.
